// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: FSM encoding and op codes.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add4bit.sv
// 4-bit carry-lookahead adder slice with group generate/propagate outputs.
module add4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c0,
    output logic [3:0] S,
    output logic       c4,
    output logic       Gm,
    output logic       Pm
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    // Lookahead carries computed directly from generate/propagate terms.
    always_comb begin
        w_g    = x & y;
        w_p    = x ^ y;
        w_c[0] = c0;
        w_c[1] = w_g[0] | (w_p[0] & c0);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c0);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & c0);
        Gm     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        Pm     = &w_p;
        c4     = Gm | (Pm & c0);
        S      = w_p ^ w_c;
    end

endmodule

// File: rtl/nibble_serial_alu_seq.sv
// Multi-cycle add/subtract: operands stream LSB-first through one shared 4-bit
// CLA slice, one nibble per cycle, with the carry chained through a register.
module nibble_serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NNIB  = WIDTH / 4;
    localparam int CNT_W = $clog2(NNIB);
    localparam int IDX_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NNIB - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [IDX_W-1:0] w_base;
    logic [3:0]       w_x;
    logic [3:0]       w_y;
    logic [3:0]       w_s;
    logic             w_c4;
    // Group generate/propagate are not needed for a single serial slice.
    logic             w_gm_unused;
    logic             w_pm_unused;

    assign w_last = (r_cnt == LAST_CNT);
    assign w_base = {r_cnt, 2'b00};
    assign w_x    = r_opa[w_base +: 4];
    assign w_y    = r_opb[w_base +: 4];

    add4bit u_slice (
        .x  (w_x),
        .y  (w_y),
        .c0 (r_carry),
        .S  (w_s),
        .c4 (w_c4),
        .Gm (w_gm_unused),
        .Pm (w_pm_unused)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state, handshake outputs and operand-accept decode.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand latch, nibble-serial datapath and final flag capture.
    // NOTE: the operand registers are reset too, so the slice never sees X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_opa <= a;
            r_cnt <= '0;
            unique case (op)
                OP_ADD: begin
                    r_opb   <= b;
                    r_carry <= 1'b0;
                end
                OP_SUB: begin
                    r_opb   <= ~b;
                    r_carry <= 1'b1;
                end
                default: begin
                    r_opb   <= b;
                    r_carry <= 1'b0;
                end
            endcase
        end else if (r_state == ST_RUN) begin
            r_result[w_base +: 4] <= w_s;
            r_carry               <= w_c4;
            if (w_last) begin
                // Counter holds at the last nibble rather than wrapping.
                r_cout     <= w_c4;
                r_overflow <= (r_opa[WIDTH-1] == r_opb[WIDTH-1])
                           && (w_s[3] != r_opa[WIDTH-1]);
                r_zero     <= ({w_s, r_result[WIDTH-5:0]} == '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule
